// File: rtl/jedro_1_mem_arb.sv
// jedro_1_mem_arb: shares one single-port synchronous memory (fixed 1-cycle read latency)
// between the instruction fetch unit (IFU) and the load/store unit (LSU).
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   ifu_req_i/ifu_addr_i     IFU read request and address
//   ifu_flush_i              drop the IFU response due this cycle (jump/flush)
//   ifu_gnt_o                IFU request accepted this cycle (combinational)
//   ifu_rvalid_o/ifu_rdata_o IFU read response
//   lsu_req_i/lsu_we_i/lsu_be_i/lsu_addr_i/lsu_wdata_i  LSU request
//   lsu_gnt_o                LSU request accepted this cycle (combinational)
//   lsu_rvalid_o/lsu_rdata_o LSU response (acknowledge for writes)
//   mem_*_o / mem_rdata_i    memory port; read data arrives one cycle after mem_en_o
//
// LSU wins by default. A starve counter tracks consecutive cycles where the IFU was
// requesting but denied; once it reaches STARVE_LIMIT the IFU wins unconditionally.
module jedro_1_mem_arb #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  // IFU port
  input  logic                    ifu_req_i,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  input  logic                    ifu_flush_i,
  output logic                    ifu_gnt_o,
  output logic                    ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  // LSU port
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  // Memory port
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned CntW = 4;  // covers STARVE_LIMIT up to 15
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  // Who owns the response returning from memory in the current cycle.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIfu  = 2'd1,
    OwnLsu  = 2'd2
  } owner_e;

  owner_e          owner_q, owner_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic ifu_win;
  logic lsu_win;
  logic ifu_starved;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  always_comb begin
    ifu_win     = 1'b0;
    lsu_win     = 1'b0;
    ifu_starved = ifu_req_i && (starve_q == StarveMax);
    if (ifu_starved) begin
      ifu_win = 1'b1;
    end else if (lsu_req_i) begin
      lsu_win = 1'b1;
    end else if (ifu_req_i) begin
      ifu_win = 1'b1;
    end
  end

  // Grants are forced low while reset is asserted, since they are combinational.
  assign ifu_gnt_o = rstn_i & ifu_win;
  assign lsu_gnt_o = rstn_i & lsu_win;

  // ---------------------------------------------------------------------------
  // Memory request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ifu_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = ifu_addr_i;
    end else if (lsu_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = lsu_we_i;
      mem_be_o    = lsu_be_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner and starve counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d  = OwnNone;
    starve_d = '0;
    if (ifu_gnt_o) begin
      owner_d = OwnIfu;
    end else if (lsu_gnt_o) begin
      owner_d = OwnLsu;
    end
    // Denied IFU request: count up and saturate; any grant or idle IFU clears.
    if (ifu_req_i && !ifu_gnt_o) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end
  end

  // Asynchronous reset drops any in-flight response along with the owner.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q  <= OwnNone;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  always_comb begin
    ifu_rvalid_o = (owner_q == OwnIfu) && !ifu_flush_i;
    lsu_rvalid_o = (owner_q == OwnLsu);
    ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
    lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_jedro_1_mem_arb.sv
// Directed bench for jedro_1_mem_arb: a table of per-cycle vectors with hand-computed
// expectations, followed by hand-written reset sequences. A small word-addressed
// memory with one-cycle read latency sits on the memory port.
module tb_jedro_1_mem_arb;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        ifu_req_i, ifu_flush_i, ifu_gnt_o, ifu_rvalid_o;
  logic [31:0] ifu_addr_i, ifu_rdata_o;
  logic        lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  jedro_1_mem_arb #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .ifu_req_i    (ifu_req_i),
    .ifu_addr_i   (ifu_addr_i),
    .ifu_flush_i  (ifu_flush_i),
    .ifu_gnt_o    (ifu_gnt_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .ifu_rdata_o  (ifu_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  // 16-word memory; writes return 0 on the read port.
  logic [31:0] mem [16];

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) mem[mem_addr_o[5:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
        mem_rdata_i <= 32'h0;
      end else begin
        mem_rdata_i <= mem[mem_addr_o[5:2]];
      end
    end
  end

  typedef struct {
    logic [31:0] ir, ia, fl, lr, lw, lb, la, ld;                   // inputs
    logic [31:0] eig, elg, een, ewe, ebe, ead, ewd;                // same-cycle outputs
    logic [31:0] eirv, eird, elrv, elrd, clrd;                     // responses; clrd: check lsu_rdata
  } vec_t;

  localparam int NumVec = 29;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ifu_gnt"},    32'(ifu_gnt_o),    32'h0);
    check({tag, " lsu_gnt"},    32'(lsu_gnt_o),    32'h0);
    check({tag, " ifu_rvalid"}, 32'(ifu_rvalid_o), 32'h0);
    check({tag, " ifu_rdata"},  ifu_rdata_o,       32'h0);
    check({tag, " lsu_rvalid"}, 32'(lsu_rvalid_o), 32'h0);
    check({tag, " lsu_rdata"},  lsu_rdata_o,       32'h0);
    check({tag, " mem_en"},     32'(mem_en_o),     32'h0);
    check({tag, " mem_we"},     32'(mem_we_o),     32'h0);
    check({tag, " mem_be"},     32'(mem_be_o),     32'h0);
  endtask

  task automatic idle_inputs();
    ifu_req_i   = 1'b0;
    ifu_addr_i  = 32'h0;
    ifu_flush_i = 1'b0;
    lsu_req_i   = 1'b0;
    lsu_we_i    = 1'b0;
    lsu_be_i    = 4'h0;
    lsu_addr_i  = 32'h0;
    lsu_wdata_i = 32'h0;
  endtask

  initial begin
    vec_t v;
    // Row layout: ir ia fl lr lw lb la ld | eig elg een ewe ebe ead ewd | eirv eird elrv elrd clrd
    vecs[0]  = '{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,                      0,0,0,0,1};
    vecs[1]  = '{1,4,0,0,0,0,0,0,                 1,0,1,0,'hF,4,0,                    0,0,0,0,1};
    vecs[2]  = '{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,                      1,1,0,0,1};
    vecs[3]  = '{1,8,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,0,0,1};
    vecs[4]  = '{1,8,0,0,0,0,0,0,                 1,0,1,0,'hF,8,0,                    0,0,1,'h2020,1};
    vecs[5]  = '{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,                      1,'h22,0,0,1};
    vecs[6]  = '{0,0,0,1,1,3,'h10,'hDEADBEEF,     0,1,1,1,3,'h10,'hDEADBEEF,          0,0,0,0,1};
    vecs[7]  = '{0,0,0,1,0,'hF,'h10,0,            0,1,1,0,'hF,'h10,0,                 0,0,1,0,0};
    vecs[8]  = '{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,                      0,0,1,'hBEEF,1};
    // Starvation: both requesting for six cycles
    vecs[9]  = '{1,4,0,1,0,'hF,8,0,               0,1,1,0,'hF,8,0,                    0,0,0,0,1};
    vecs[10] = '{1,4,0,1,0,'hF,8,0,               0,1,1,0,'hF,8,0,                    0,0,1,'h22,1};
    vecs[11] = '{1,4,0,1,0,'hF,8,0,               0,1,1,0,'hF,8,0,                    0,0,1,'h22,1};
    vecs[12] = '{1,4,0,1,0,'hF,8,0,               0,1,1,0,'hF,8,0,                    0,0,1,'h22,1};
    vecs[13] = '{1,4,0,1,0,'hF,8,0,               1,0,1,0,'hF,4,0,                    0,0,1,'h22,1};
    vecs[14] = '{1,4,0,1,0,'hF,8,0,               0,1,1,0,'hF,8,0,                    1,1,0,0,1};
    vecs[15] = '{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,                      0,0,1,'h22,1};
    // A cycle with ifu_req low clears the counter
    vecs[16] = '{1,4,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,0,0,1};
    vecs[17] = '{0,0,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,1,'h2020,1};
    vecs[18] = '{1,4,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,1,'h2020,1};
    vecs[19] = '{1,4,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,1,'h2020,1};
    vecs[20] = '{1,4,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,1,'h2020,1};
    vecs[21] = '{1,4,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,1,'h2020,1};
    vecs[22] = '{1,4,0,1,0,'hF,'h20,0,            1,0,1,0,'hF,4,0,                    0,0,1,'h2020,1};
    vecs[23] = '{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,                      1,1,0,0,1};
    // Flush drops the in-flight IFU response but not the new grant
    vecs[24] = '{1,0,0,0,0,0,0,0,                 1,0,1,0,'hF,0,0,                    0,0,0,0,1};
    vecs[25] = '{1,4,1,0,0,0,0,0,                 1,0,1,0,'hF,4,0,                    0,0,0,0,1};
    vecs[26] = '{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,                      1,1,0,0,1};
    // Flush has no effect on an LSU response
    vecs[27] = '{0,0,0,1,0,'hF,'h20,0,            0,1,1,0,'hF,'h20,0,                 0,0,0,0,1};
    vecs[28] = '{0,0,1,0,0,0,0,0,                 0,0,0,0,0,0,0,                      0,0,1,'h2020,1};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hA0A0_A0A0;
    mem[1] = 32'h0000_0001;
    mem[2] = 32'h0000_0022;
    mem[8] = 32'h0000_2020;
    mem_rdata_i = 32'h0;

    // Reset with both requests asserted: everything held at zero.
    rstn_i = 1'b0;
    idle_inputs();
    ifu_req_i = 1'b1;
    ifu_addr_i = 32'h4;
    lsu_req_i = 1'b1;
    lsu_we_i  = 1'b1;
    lsu_be_i  = 4'hF;
    #12;
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    idle_inputs();
    rstn_i = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(posedge clk_i);
      #1;
      v = vecs[i];
      ifu_req_i   = v.ir[0];
      ifu_addr_i  = v.ia;
      ifu_flush_i = v.fl[0];
      lsu_req_i   = v.lr[0];
      lsu_we_i    = v.lw[0];
      lsu_be_i    = v.lb[3:0];
      lsu_addr_i  = v.la;
      lsu_wdata_i = v.ld;
      #4;
      check($sformatf("v%0d ifu_gnt", i),    32'(ifu_gnt_o),    v.eig);
      check($sformatf("v%0d lsu_gnt", i),    32'(lsu_gnt_o),    v.elg);
      check($sformatf("v%0d mem_en", i),     32'(mem_en_o),     v.een);
      check($sformatf("v%0d mem_we", i),     32'(mem_we_o),     v.ewe);
      check($sformatf("v%0d mem_be", i),     32'(mem_be_o),     v.ebe);
      if (v.een[0]) begin
        check($sformatf("v%0d mem_addr", i),  mem_addr_o,  v.ead);
        check($sformatf("v%0d mem_wdata", i), mem_wdata_o, v.ewd);
      end
      check($sformatf("v%0d ifu_rvalid", i), 32'(ifu_rvalid_o), v.eirv);
      check($sformatf("v%0d ifu_rdata", i),  ifu_rdata_o,       v.eird);
      check($sformatf("v%0d lsu_rvalid", i), 32'(lsu_rvalid_o), v.elrv);
      if (v.clrd[0]) check($sformatf("v%0d lsu_rdata", i), lsu_rdata_o, v.elrd);
    end

    // Reset mid-transaction: IFU read granted, reset lands before its response.
    @(posedge clk_i);
    #1;
    idle_inputs();
    ifu_req_i  = 1'b1;
    ifu_addr_i = 32'h8;
    #4;
    check("midrst grant", 32'(ifu_gnt_o), 32'h1);
    @(posedge clk_i);
    #1;
    rstn_i    = 1'b0;
    lsu_req_i = 1'b1;
    lsu_we_i  = 1'b1;
    lsu_be_i  = 4'hF;
    #1;
    check_all_zero("midrst");
    @(posedge clk_i);
    #1;
    idle_inputs();
    rstn_i = 1'b1;
    #4;
    check("post-rst ifu_rvalid a", 32'(ifu_rvalid_o), 32'h0);
    check("post-rst lsu_rvalid a", 32'(lsu_rvalid_o), 32'h0);
    check("post-rst mem_en", 32'(mem_en_o), 32'h0);
    @(posedge clk_i);
    #5;
    check("post-rst ifu_rvalid b", 32'(ifu_rvalid_o), 32'h0);
    check("post-rst lsu_rvalid b", 32'(lsu_rvalid_o), 32'h0);
    @(posedge clk_i);
    #1;
    ifu_req_i  = 1'b1;
    ifu_addr_i = 32'h4;
    #4;
    check("post-rst new grant", 32'(ifu_gnt_o), 32'h1);
    @(posedge clk_i);
    #1;
    idle_inputs();
    #4;
    check("post-rst new rvalid", 32'(ifu_rvalid_o), 32'h1);
    check("post-rst new rdata",  ifu_rdata_o,       32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
